// File: rtl/cv32e40p_apu_wb_buf.sv
// APU write-back buffer: holds APU results that lose the regfile write port
// and retires them strictly in order, with a decode-stage dependency check.
module cv32e40p_apu_wb_buf #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FLAGS_WIDTH = 5,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  apu_result_i,
  input  logic [FLAGS_WIDTH-1:0] apu_flags_i,
  input  logic [5:0]             apu_waddr_i,
  input  logic                   wb_conflict_i,
  output logic                   wb_we_o,
  output logic [5:0]             wb_waddr_o,
  output logic [DATA_WIDTH-1:0]  wb_wdata_o,
  output logic                   fflags_we_o,
  output logic [FLAGS_WIDTH-1:0] fflags_o,
  input  logic [2:0][5:0]        read_regs_i,
  input  logic [2:0]             read_regs_valid_i,
  output logic                   read_dep_o,
  output logic [CW-1:0]          count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o
);

  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [5:0]             mem_waddr_q [DEPTH];
  logic [5:0]             mem_waddr_d [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_data_q  [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_data_d  [DEPTH];
  logic [FLAGS_WIDTH-1:0] mem_flags_q [DEPTH];
  logic [FLAGS_WIDTH-1:0] mem_flags_d [DEPTH];

  logic empty_s, full_s, deq_s, bypass_s, enq_req_s, accept_s, drop_s, dep_s;
  logic [PW-1:0] idx_s;

  // Retirement / acceptance decisions; the head always beats the incoming result.
  always_comb begin
    empty_s   = (count_q == {CW{1'b0}});
    full_s    = (count_q == CW'(DEPTH));
    deq_s     = !empty_s && !wb_conflict_i;
    bypass_s  = empty_s && apu_rvalid_i && !wb_conflict_i;
    enq_req_s = apu_rvalid_i && !bypass_s;
    accept_s  = enq_req_s && (!full_s || deq_s);
    drop_s    = enq_req_s && full_s && !deq_s;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    head_d     = deq_s    ? head_q + PW'(1) : head_q;
    tail_d     = accept_s ? tail_q + PW'(1) : tail_q;
    overflow_d = overflow_q | drop_s;
    case ({accept_s, deq_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write at the tail; when full with a dequeue the tail slot is the
  // retiring head, which has already been driven out this cycle.
  always_comb begin
    mem_waddr_d = mem_waddr_q;
    mem_data_d  = mem_data_q;
    mem_flags_d = mem_flags_q;
    if (accept_s) begin
      mem_waddr_d[tail_q] = apu_waddr_i;
      mem_data_d[tail_q]  = apu_result_i;
      mem_flags_d[tail_q] = apu_flags_i;
    end else begin
      mem_waddr_d = mem_waddr_q;
    end
  end

  // Regfile / fflags write port: head first, then bypass, otherwise all zero.
  always_comb begin
    wb_we_o    = 1'b0;
    wb_waddr_o = 6'd0;
    wb_wdata_o = {DATA_WIDTH{1'b0}};
    fflags_o   = {FLAGS_WIDTH{1'b0}};
    if (rst_ni && deq_s) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = mem_waddr_q[head_q];
      wb_wdata_o = mem_data_q[head_q];
      fflags_o   = mem_flags_q[head_q];
    end else if (rst_ni && bypass_s) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = apu_waddr_i;
      wb_wdata_o = apu_result_i;
      fflags_o   = apu_flags_i;
    end else begin
      wb_we_o    = 1'b0;
    end
    fflags_we_o = wb_we_o;
  end

  // Dependency check: live entries except the one retiring now, plus an
  // incoming result that is not being written this cycle.
  always_comb begin
    dep_s = 1'b0;
    idx_s = {PW{1'b0}};
    for (int s = 0; s < 3; s++) begin
      if (read_regs_valid_i[s]) begin
        for (int k = 0; k < DEPTH; k++) begin
          idx_s = head_q + PW'(k);
          if ((CW'(k) < count_q) && !((k == 0) && deq_s) &&
              (mem_waddr_q[idx_s] == read_regs_i[s])) begin
            dep_s = 1'b1;
          end else begin
            dep_s = dep_s;
          end
        end
        if (enq_req_s && (apu_waddr_i == read_regs_i[s])) begin
          dep_s = 1'b1;
        end else begin
          dep_s = dep_s;
        end
      end else begin
        dep_s = dep_s;
      end
    end
    read_dep_o = rst_ni & dep_s;
  end

  always_comb begin
    count_o    = count_q;
    full_o     = full_s;
    empty_o    = empty_s;
    overflow_o = overflow_q;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage is deliberately not reset; validity comes from count only.
  always_ff @(posedge clk_i) begin
    mem_waddr_q <= mem_waddr_d;
    mem_data_q  <= mem_data_d;
    mem_flags_q <= mem_flags_d;
  end

endmodule
